axis_input_packer: RTL and testbench

AXIS_INPUT_PACKER -- requirements
Module: axis_input_packer

---
 rtl/axis_input_packer_pkg.sv | 21 ++
 rtl/axis_pack_reg.sv | 50 +++++
 rtl/axis_input_packer.sv | 180 ++++++++++++++++++
 tb/tb_axis_input_packer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_input_packer_pkg.sv
// Shared types and size derivation for the input packer and the shift buffer it feeds.
package axis_input_packer_pkg;

    localparam int DATA_WIDTH_DEF   = 16;
    localparam int CONV_UNITS_DEF   = 8;
    localparam int KERNEL_H_MAX_DEF = 3;

    // Words per packed beat: core rows plus the kernel overlap rows.
    function automatic int pack_words(input int conv_units, input int kernel_h_max);
        return conv_units + kernel_h_max - 32'sd1;
    endfunction

    function automatic int cnt_bits(input int n);
        return (n < 32'sd2) ? 32'sd1 : $clog2(n);
    endfunction

    localparam int PACK_WORDS_DEF = pack_words(CONV_UNITS_DEF, KERNEL_H_MAX_DEF);

    typedef logic [DATA_WIDTH_DEF-1:0] word_t;

endpackage

// File: rtl/axis_pack_reg.sv
// Valid/ready output register holding one packed beat of N words plus its tlast flag.
module axis_pack_reg
    import axis_input_packer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int N          = PACK_WORDS_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  ld_i,
    input  logic                  ld_valid_i,
    input  logic                  ld_last_i,
    input  logic [DATA_WIDTH-1:0] ld_data_i [N-1:0],
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o [N-1:0],
    output logic                  valid_o,
    output logic                  last_o,
    output logic                  can_load_o
);

    logic [DATA_WIDTH-1:0] data_q [N-1:0];
    logic                  valid_q;
    logic                  last_q;

    // Beat register: a load replaces the words, a consumed beat drops valid and last.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q  <= '{default: '0};
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            if (ld_i) begin
                data_q <= ld_data_i;
            end
            if (ld_i && ld_valid_i) begin
                valid_q <= 1'b1;
                last_q  <= ld_last_i;
            end else if (ready_i) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign last_o     = last_q;
    assign can_load_o = !valid_q || ready_i;

endmodule

// File: rtl/axis_input_packer.sv
// Packs a word-per-beat AXI-Stream into N-word beats, zero-padding a pack cut short by tlast.
// Build option AXIS_PACKER_DOUBLE_BUFFER_EN adds a collect register so input keeps flowing while the output stalls.
module axis_input_packer
    import axis_input_packer_pkg::*;
#(
    parameter int  DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int  CONV_UNITS   = CONV_UNITS_DEF,
    parameter int  KERNEL_H_MAX = KERNEL_H_MAX_DEF,
    localparam int N            = pack_words(CONV_UNITS, KERNEL_H_MAX)
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                  S_AXIS_tvalid,
    input  logic                  S_AXIS_tlast,
    output logic                  S_AXIS_tready,
    output logic [DATA_WIDTH-1:0] M_AXIS_tdata [N-1:0],
    output logic                  M_AXIS_tvalid,
    output logic                  M_AXIS_tlast,
    input  logic                  M_AXIS_tready
);

    localparam int              CW       = cnt_bits(N);
    localparam logic [CW-1:0]   LAST_IDX = CW'(N - 1);

    logic                  rdy_en_q;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic [CW-1:0]         idx_s;
    logic                  hs_s;
    logic                  done_s;
    logic                  tready_s;
    logic                  can_load_s;
    logic                  ld_s;
    logic                  ld_valid_s;
    logic                  ld_last_s;
    logic [DATA_WIDTH-1:0] base_s   [N-1:0];
    logic [DATA_WIDTH-1:0] merged_s [N-1:0];
    logic [DATA_WIDTH-1:0] ld_data_s [N-1:0];

    // Input acceptance is held off until the first edge after reset release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
        end
    end

    assign S_AXIS_tready = tready_s;
    assign hs_s          = S_AXIS_tvalid && tready_s;
    assign idx_s         = start ? '0 : cnt_q;
    assign done_s        = S_AXIS_tlast || (idx_s == LAST_IDX);

    // Word counter: start clears before the current word is placed.
    always_comb begin
        cnt_d = cnt_q;
        if (hs_s) begin
            if (done_s) begin
                cnt_d = '0;
            end else begin
                cnt_d = idx_s + 1'b1;
            end
        end else if (start) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Word counter register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Earlier positions keep the pack in progress; later ones read zero, which pads an early tlast.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (CW'(i) < idx_s) begin
                merged_s[i] = base_s[i];
            end else if (CW'(i) == idx_s) begin
                merged_s[i] = S_AXIS_tdata;
            end else begin
                merged_s[i] = '0;
            end
        end
    end

`ifdef AXIS_PACKER_DOUBLE_BUFFER_EN
    logic [DATA_WIDTH-1:0] col_q [N-1:0];
    logic [DATA_WIDTH-1:0] col_d [N-1:0];
    logic                  full_q;
    logic                  full_d;
    logic                  col_last_q;
    logic                  col_last_d;
    logic                  xfer_s;
    logic                  bypass_s;

    assign xfer_s   = full_q && can_load_s;
    assign bypass_s = hs_s && done_s && !full_q && can_load_s;
    assign tready_s = rdy_en_q && (!full_q || can_load_s);
    assign base_s   = col_q;

    // A finished pack goes straight out when the output is free, otherwise it waits in the collect register.
    always_comb begin
        col_d      = col_q;
        full_d     = full_q;
        col_last_d = col_last_q;
        ld_s       = xfer_s || bypass_s;
        ld_valid_s = 1'b1;
        ld_last_s  = S_AXIS_tlast;
        ld_data_s  = merged_s;
        if (xfer_s) begin
            full_d    = 1'b0;
            ld_last_s = col_last_q;
            ld_data_s = col_q;
        end else begin
            full_d    = full_q;
        end
        if (hs_s) begin
            col_d = merged_s;
            if (done_s && !bypass_s) begin
                full_d     = 1'b1;
                col_last_d = S_AXIS_tlast;
            end else begin
                col_last_d = col_last_q;
            end
        end else begin
            col_d = col_q;
        end
    end

    // Collect register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            col_q      <= '{default: '0};
            full_q     <= 1'b0;
            col_last_q <= 1'b0;
        end else begin
            col_q      <= col_d;
            full_q     <= full_d;
            col_last_q <= col_last_d;
        end
    end
`else
    assign tready_s = rdy_en_q && can_load_s;
    assign base_s   = M_AXIS_tdata;

    // The output register doubles as the collect register; valid rises only on the completing word.
    always_comb begin
        ld_s       = hs_s;
        ld_valid_s = done_s;
        ld_last_s  = S_AXIS_tlast;
        ld_data_s  = merged_s;
    end
`endif

    axis_pack_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N)
    ) u_pack_reg (
        .clk_i      (aclk),
        .rst_n_i    (aresetn),
        .ld_i       (ld_s),
        .ld_valid_i (ld_valid_s),
        .ld_last_i  (ld_last_s),
        .ld_data_i  (ld_data_s),
        .ready_i    (M_AXIS_tready),
        .data_o     (M_AXIS_tdata),
        .valid_o    (M_AXIS_tvalid),
        .last_o     (M_AXIS_tlast),
        .can_load_o (can_load_s)
    );

endmodule

// File: tb/tb_axis_input_packer.sv
// Bench for axis_input_packer: directed scenarios plus random traffic against a queue-based pack model.
// Expectations follow AXIS_PACKER_DOUBLE_BUFFER_EN when it is defined for the build.
module tb_axis_input_packer;
    import axis_input_packer_pkg::*;

    localparam int DW = DATA_WIDTH_DEF;
    localparam int N  = PACK_WORDS_DEF;
`ifdef AXIS_PACKER_DOUBLE_BUFFER_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif
    typedef logic [N*DW-1:0] flat_t;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          start;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tready;
    logic [DW-1:0] m_tdata [N-1:0];
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready;

    int total = 0;
    int bad   = 0;
    int rdy_mode = 0;

    flat_t         exp_d[$];
    logic          exp_l[$];
    logic [DW-1:0] part[$];
    flat_t         rx_d[$];
    logic          rx_l[$];

    axis_input_packer dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .start         (start),
        .S_AXIS_tdata  (s_tdata),
        .S_AXIS_tvalid (s_tvalid),
        .S_AXIS_tlast  (s_tlast),
        .S_AXIS_tready (s_tready),
        .M_AXIS_tdata  (m_tdata),
        .M_AXIS_tvalid (m_tvalid),
        .M_AXIS_tlast  (m_tlast),
        .M_AXIS_tready (m_tready)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    function automatic flat_t flat(input logic [DW-1:0] a [N-1:0]);
        flat_t r;
        for (int k = 0; k < N; k++) r[k*DW +: DW] = a[k];
        return r;
    endfunction

    function automatic flat_t mk(input int first, input int cnt);
        flat_t r;
        r = '0;
        for (int k = 0; k < cnt; k++) r[k*DW +: DW] = DW'(first + k);
        return r;
    endfunction

    // Output-side ready pattern: 0 always ready, 1 stalled, 2 random.
    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            case (rdy_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = 1'b0;
                default: m_tready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Compare process: model the packs from accepted words and check every output cycle.
    bit    imm_pend   = 1'b0;
    flat_t imm_d;
    bit    stall_prev = 1'b0;
    flat_t prev_d;
    logic  prev_v;
    logic  prev_l;
    int    since_rst  = 0;

    always @(negedge aclk) begin
        flat_t cur;
        flat_t b;
        cur = flat(m_tdata);
        if (!aresetn) begin
            chk("rst_tvalid", m_tvalid, 1'b0);
            chk("rst_tlast", m_tlast, 1'b0);
            chk("rst_tdata", cur, '0);
            chk("rst_tready", s_tready, 1'b0);
            exp_d.delete();
            exp_l.delete();
            part.delete();
            imm_pend   = 1'b0;
            stall_prev = 1'b0;
            since_rst  = 0;
        end else begin
            since_rst++;
            if (imm_pend) begin
                chk("latency_valid", m_tvalid, 1'b1);
                chk("latency_data", cur, imm_d);
                imm_pend = 1'b0;
            end
            if (stall_prev) begin
                chk("hold_data", cur, prev_d);
                chk("hold_valid", m_tvalid, prev_v);
                chk("hold_last", m_tlast, prev_l);
            end
            if (since_rst >= 2)
                chk("s_tready", s_tready, !(exp_d.size() >= CAP && !m_tready));
            if (m_tvalid && m_tready) begin
                rx_d.push_back(cur);
                rx_l.push_back(m_tlast);
                if (exp_d.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %h want none", cur);
                end else begin
                    chk("beat_data", cur, exp_d.pop_front());
                    chk("beat_last", m_tlast, exp_l.pop_front());
                end
            end
            if (start) part.delete();
            if (s_tvalid && s_tready) begin
                part.push_back(s_tdata);
                if (part.size() == N || s_tlast) begin
                    b = '0;
                    for (int k = 0; k < part.size(); k++) b[k*DW +: DW] = part[k];
                    if (exp_d.size() == 0) begin
                        imm_pend = 1'b1;
                        imm_d    = b;
                    end
                    exp_d.push_back(b);
                    exp_l.push_back(s_tlast);
                    part.delete();
                end
            end
            stall_prev = m_tvalid && !m_tready;
            prev_d     = cur;
            prev_v     = m_tvalid;
            prev_l     = m_tlast;
        end
    end

    task automatic send(input logic [DW-1:0] w, input logic l, input logic st);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        s_tdata  = w;
        s_tlast  = l;
        s_tvalid = 1'b1;
        start    = st;
        while (!done) begin
            @(negedge aclk);
            if (s_tready) done = 1'b1;
            @(posedge aclk);
            #1;
            start = 1'b0;
            n++;
            if (!done && n > 100) begin
                total++;
                bad++;
                $display("FAIL send_timeout: got no accept want accept of %h", w);
                done = 1'b1;
            end
        end
    endtask

    task automatic idle(input int k);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        start    = 1'b0;
        repeat (k) begin
            @(posedge aclk);
            #1;
        end
    endtask

    initial begin
        int  base;
        int  n;
        time t0;
        aresetn  = 1'b0;
        start    = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        idle(3);
        aresetn = 1'b1;
        idle(2);
        chk("tready_after_reset", s_tready, 1'b1);

        // Twenty words, no tlast, no stall.
        base = rx_d.size();
        t0   = $time;
        for (int i = 0; i < 20; i++) send(DW'(i), 1'b0, 1'b0);
        chk("no_bubble_time", $time - t0, 200);
        idle(3);
        chk("t20_beats", rx_d.size() - base, 2);
        chk("t20_b0", rx_d[base], mk(0, 10));
        chk("t20_b0_last", rx_l[base], 1'b0);
        chk("t20_b1", rx_d[base+1], mk(10, 10));
        chk("t20_b1_last", rx_l[base+1], 1'b0);

        // Thirteen words, tlast on the last one.
        base = rx_d.size();
        for (int i = 0; i < 13; i++) send(DW'(i), (i == 12), 1'b0);
        idle(3);
        chk("t13_beats", rx_d.size() - base, 2);
        chk("t13_b1", rx_d[base+1], mk(10, 3));
        chk("t13_b1_last", rx_l[base+1], 1'b1);

        // tlast exactly on the tenth word.
        base = rx_d.size();
        for (int i = 0; i < 10; i++) send(DW'(i), (i == 9), 1'b0);
        idle(5);
        chk("t10_beats", rx_d.size() - base, 1);
        chk("t10_b0", rx_d[base], mk(0, 10));
        chk("t10_last", rx_l[base], 1'b1);

        // tlast on word 0.
        base = rx_d.size();
        send(DW'(55), 1'b1, 1'b0);
        idle(3);
        chk("w0_last_beat", rx_d[base], mk(55, 1));
        chk("w0_last_flag", rx_l[base], 1'b1);

        // Start after four words discards them.
        base = rx_d.size();
        for (int i = 0; i < 4; i++) send(DW'(i), 1'b0, 1'b0);
        idle(1);
        start = 1'b1;
        @(posedge aclk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) send(DW'(100 + i), 1'b0, 1'b0);
        idle(3);
        chk("start_beats", rx_d.size() - base, 1);
        chk("start_b0", rx_d[base], mk(100, 10));

        // Start together with a handshake: that word lands at position 0.
        base = rx_d.size();
        for (int i = 0; i < 3; i++) send(DW'(i + 1), 1'b0, 1'b0);
        send(DW'(7), 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) send(DW'(8 + i), 1'b0, 1'b0);
        idle(3);
        chk("start_hs_b0", rx_d[base], mk(7, 10));

        // Output stalled after beat 0.
        rdy_mode = 1;
        idle(2);
        base = rx_d.size();
        for (int i = 0; i < 10; i++) send(DW'(i), 1'b0, 1'b0);
`ifdef AXIS_PACKER_DOUBLE_BUFFER_EN
        for (int i = 0; i < 10; i++) send(DW'(10 + i), 1'b0, 1'b0);
        idle(1);
        @(negedge aclk);
        chk("stall_tready", s_tready, 1'b0);
        idle(13);
        chk("stall_no_beat", rx_d.size() - base, 0);
        rdy_mode = 0;
        idle(4);
`else
        @(negedge aclk);
        chk("stall_tready", s_tready, 1'b0);
        idle(15);
        chk("stall_no_beat", rx_d.size() - base, 0);
        rdy_mode = 0;
        idle(2);
        for (int i = 0; i < 10; i++) send(DW'(10 + i), 1'b0, 1'b0);
        idle(3);
`endif
        chk("stall_beats", rx_d.size() - base, 2);
        chk("stall_b0", rx_d[base], mk(0, 10));
        chk("stall_b1", rx_d[base+1], mk(10, 10));

        // Reset in the middle of a pack.
        base = rx_d.size();
        for (int i = 0; i < 7; i++) send(DW'(i), 1'b0, 1'b0);
        idle(1);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_tvalid", m_tvalid, 1'b0);
        chk("mid_rst_tready", s_tready, 1'b0);
        idle(2);
        aresetn = 1'b1;
        idle(2);
        for (int i = 0; i < 10; i++) send(DW'(200 + i), 1'b0, 1'b0);
        idle(3);
        chk("rst_beats", rx_d.size() - base, 1);
        chk("rst_b0", rx_d[base], mk(200, 10));
        chk("rst_b0_last", rx_l[base], 1'b0);

        // Random traffic against the model.
        rdy_mode = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send(DW'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 29) == 0));
        end
        idle(1);
        rdy_mode = 0;
        n = 0;
        while (exp_d.size() != 0 && n < 100) begin
            @(posedge aclk);
            n++;
        end
        #1;
        chk("drain_empty", exp_d.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
